spike_injector: RTL and testbench

//   Host-side spike source for one mesh boundary port. Buffers host spike events in a FIFO, releases

---
 rtl/noc_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/spike_injector.sv | 120 ++++++++++++
 tb/tb_spike_injector.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared mesh packet layout and spike-injector state encoding.
package noc_pkg;

  localparam int PKT_X_HI      = 31;
  localparam int PKT_X_LO      = 28;
  localparam int PKT_Y_HI      = 27;
  localparam int PKT_Y_LO      = 24;
  localparam int PKT_NEURON_HI = 23;
  localparam int PKT_NEURON_LO = 16;
  localparam int PKT_TAG_HI    = 15;
  localparam int PKT_TAG_LO    = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } inj_state_e;

  function automatic logic [31:0] pkt_pack(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic [7:0] neuron,
                                           input logic [7:0] tag);
    logic [31:0] p;
    p = '0;
    p[PKT_X_HI:PKT_X_LO]           = x;
    p[PKT_Y_HI:PKT_Y_LO]           = y;
    p[PKT_NEURON_HI:PKT_NEURON_LO] = neuron;
    p[PKT_TAG_HI:PKT_TAG_LO]       = tag;
    return p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with registered occupancy; rejects writes when
// full and reads when empty.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_en_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_d;
  logic                  do_wr, do_rd;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/spike_injector.sv
// Host spike source for a mesh edge port: buffers tagged events and releases
// each one onto din/vin once the global timestep has reached its tag.
module spike_injector
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          host_wr_en,
  input  logic [3:0]                    host_dest_x,
  input  logic [3:0]                    host_dest_y,
  input  logic [7:0]                    host_neuron,
  input  logic [TAG_WIDTH-1:0]          host_tag,
  output logic                          host_full,
  input  logic                          step_tick,
  output logic [TAG_WIDTH-1:0]          cur_step,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          vout,
  input  logic                          rin,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic [15:0]                   sent_count,
  output logic                          overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] wr_data, head;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [TAG_WIDTH-1:0]  head_tag, step_diff;
  logic                  head_elig, handshake, pop;

  inj_state_e            state_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  vout_q;
  logic [TAG_WIDTH-1:0]  cur_step_q;
  logic [15:0]           sent_q;
  logic                  overflow_q;

  assign wr_data = DATA_WIDTH'(pkt_pack(host_dest_x, host_dest_y, host_neuron, 8'(host_tag)));

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (host_wr_en),
    .wr_data_i (wr_data),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Serial-number compare: the tag is due when it lies in the half-range behind cur_step.
  assign head_tag  = TAG_WIDTH'(head[PKT_TAG_HI:PKT_TAG_LO]);
  assign step_diff = cur_step_q - head_tag;
  assign head_elig = !fifo_empty && !step_diff[TAG_WIDTH-1];
  assign handshake = vout_q && rin;
  assign pop       = head_elig && ((state_q == S_IDLE) || handshake);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      dout_q  <= '0;
      vout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            dout_q  <= head;
            vout_q  <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (handshake) begin
            if (pop) begin
              dout_q <= head;
            end else begin
              vout_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          vout_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_step_q <= '0;
      sent_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (step_tick)              cur_step_q <= cur_step_q + TAG_WIDTH'(1);
      if (handshake)              sent_q     <= sent_q + 16'd1;
      if (host_wr_en && fifo_full) overflow_q <= 1'b1;
    end
  end

  assign host_full  = fifo_full;
  assign cur_step   = cur_step_q;
  assign dout       = dout_q;
  assign vout       = vout_q;
  assign pending    = fifo_count + CW'(vout_q);
  assign sent_count = sent_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_spike_injector.sv
// Directed bench for spike_injector: queue-based event model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_spike_injector;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_wr_en;
  logic [3:0]  host_dest_x, host_dest_y;
  logic [7:0]  host_neuron, host_tag;
  logic        host_full;
  logic        step_tick;
  logic [7:0]  cur_step;
  logic [31:0] dout;
  logic        vout;
  logic        rin;
  logic [4:0]  pending;
  logic [15:0] sent_count;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  spike_injector #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .TAG_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .host_wr_en  (host_wr_en),
    .host_dest_x (host_dest_x),
    .host_dest_y (host_dest_y),
    .host_neuron (host_neuron),
    .host_tag    (host_tag),
    .host_full   (host_full),
    .step_tick   (step_tick),
    .cur_step    (cur_step),
    .dout        (dout),
    .vout        (vout),
    .rin         (rin),
    .pending     (pending),
    .sent_count  (sent_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pkt;
    int          tag;
  } ev_t;

  ev_t q[$];          // every accepted event not yet handed over, oldest first
  bit  m_valid = 0;   // front of q is currently presented on the port
  int  m_sent  = 0;
  bit  m_ovf   = 0;
  int  m_cur   = 0;
  bit  model_live = 0;

  function automatic bit due(input int cur, input int tag);
    return ((cur - tag) & 255) < 128;
  endfunction

  function automatic logic [31:0] mk(input int x, input int y, input int n, input int t);
    return ((x & 15) << 28) | ((y & 15) << 24) | ((n & 255) << 16) | ((t & 255) << 8);
  endfunction

  always @(posedge clk) begin
    int  buffered;
    bit  hs;
    ev_t e;
    if (rst) begin
      q.delete();
      m_valid    = 0;
      m_sent     = 0;
      m_ovf      = 0;
      m_cur      = 0;
      model_live = 1;
    end else if (model_live) begin
      buffered = q.size() - int'(m_valid);
      hs = m_valid && rin;
      if (hs) begin
        void'(q.pop_front());
        m_sent = (m_sent + 1) & 16'hFFFF;
      end
      if (!m_valid || hs) m_valid = (q.size() > 0) && due(m_cur, q[0].tag);
      if (host_wr_en) begin
        if (buffered == DEPTH) begin
          m_ovf = 1;
        end else begin
          e.pkt = mk(host_dest_x, host_dest_y, host_neuron, host_tag);
          e.tag = host_tag;
          q.push_back(e);
        end
      end
      if (step_tick) m_cur = (m_cur + 1) & 255;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("m_vout", vout, m_valid);
      if (m_valid) check("m_dout", dout, q[0].pkt);
      check("m_pending", pending, q.size());
      check("m_full", host_full, (q.size() - int'(m_valid)) == DEPTH);
      check("m_sent", sent_count, m_sent);
      check("m_overflow", overflow, m_ovf);
      check("m_cur_step", cur_step, m_cur);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic [3:0] x, input logic [3:0] y, input logic [7:0] n, input logic [7:0] t);
    host_dest_x = x;
    host_dest_y = y;
    host_neuron = n;
    host_tag    = t;
    host_wr_en  = 1'b1;
    @(negedge clk);
    host_wr_en  = 1'b0;
  endtask

  task automatic step();
    step_tick = 1'b1;
    @(negedge clk);
    step_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    host_wr_en = 1'b0;
    host_dest_x = '0;
    host_dest_y = '0;
    host_neuron = '0;
    host_tag = '0;
    step_tick = 1'b0;
    rin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: reset state and basic two-cycle latency
    check("rst_vout", vout, 0);
    check("rst_pending", pending, 0);
    check("rst_cur_step", cur_step, 0);
    check("rst_sent", sent_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_full", host_full, 0);
    rin = 1'b1;
    wr(4'd1, 4'd0, 8'd5, 8'd0);
    check("t1_vout_early", vout, 0);
    check("t1_pending_q", pending, 1);
    @(negedge clk);
    check("t1_vout", vout, 1);
    check("t1_dout", dout, 32'h1005_0000);
    @(negedge clk);
    check("t1_vout_after", vout, 0);
    check("t1_sent", sent_count, 1);
    check("t1_pending_after", pending, 0);

    // 2: future tag waits for the timestep
    wr(4'd2, 4'd3, 8'd7, 8'd3);
    repeat (3) @(negedge clk);
    check("t2_wait_vout", vout, 0);
    repeat (3) step();
    check("t2_cur3", cur_step, 3);
    check("t2_vout_same", vout, 0);
    @(negedge clk);
    check("t2_vout", vout, 1);
    check("t2_dout", dout, 32'h2307_0300);
    @(negedge clk);
    check("t2_sent", sent_count, 2);

    // 3: backpressure holds the packet stable
    rin = 1'b0;
    wr(4'd4, 4'd4, 8'd9, 8'd3);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_vout", vout, 1);
      check("t3_hold_dout", dout, 32'h4409_0300);
      check("t3_hold_pending", pending, 1);
      @(negedge clk);
    end
    rin = 1'b1;
    @(negedge clk);
    check("t3_vout_after", vout, 0);
    check("t3_sent", sent_count, 3);
    @(negedge clk);
    check("t3_single_hs", sent_count, 3);

    // 4: fill to full with an ineligible tag, overflow, then drain in order
    rin = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) check("t4_full_at16", host_full, 1);
      host_dest_x = 4'd5;
      host_dest_y = 4'd6;
      host_neuron = 8'(i);
      host_tag    = 8'd4;
      host_wr_en  = 1'b1;
      @(negedge clk);
    end
    host_wr_en = 1'b0;
    check("t4_full", host_full, 1);
    check("t4_overflow", overflow, 1);
    check("t4_pending", pending, 16);
    rin = 1'b1;
    step();
    check("t4_cur4", cur_step, 4);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("t4_drain_vout", vout, 1);
      check("t4_drain_dout", dout, 32'h5600_0400 | (i << 16));
    end
    @(negedge clk);
    check("t4_drained_vout", vout, 0);
    check("t4_drained_pending", pending, 0);
    check("t4_sent", sent_count, 19);

    // 5: wrap-around eligibility
    step_tick = 1'b1;
    repeat (251) @(negedge clk);
    step_tick = 1'b0;
    check("t5_cur_ff", cur_step, 8'hFF);
    wr(4'd7, 4'd7, 8'd1, 8'h00);
    repeat (3) @(negedge clk);
    check("t5_wait_vout", vout, 0);
    step();
    check("t5_cur_wrap", cur_step, 0);
    @(negedge clk);
    check("t5_vout", vout, 1);
    check("t5_dout", dout, 32'h7701_0000);
    @(negedge clk);
    repeat (2) step();
    check("t5_cur2", cur_step, 2);
    wr(4'd8, 4'd9, 8'd2, 8'hFE);
    @(negedge clk);
    check("t5_past_vout", vout, 1);
    check("t5_past_dout", dout, 32'h8902_FE00);
    @(negedge clk);
    check("t5_past_done", vout, 0);

    // 6: reset during SEND with three queued
    rin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      host_dest_x = 4'd3;
      host_dest_y = 4'd3;
      host_neuron = 8'(8'h40 + i);
      host_tag    = 8'd2;
      host_wr_en  = 1'b1;
      @(negedge clk);
    end
    host_wr_en = 1'b0;
    check("t6_send_vout", vout, 1);
    check("t6_pending4", pending, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_vout", vout, 0);
    check("t6_pending", pending, 0);
    check("t6_sent", sent_count, 0);
    check("t6_overflow", overflow, 0);
    check("t6_cur_step", cur_step, 0);
    rin = 1'b1;
    wr(4'd1, 4'd1, 8'd1, 8'd0);
    @(negedge clk);
    check("t6_resume_vout", vout, 1);
    check("t6_resume_dout", dout, 32'h1101_0000);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
